// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage LoongArch pipeline.
//
// Sits between ex_stage and wb_stage. Instructions arrive with their
// data-SRAM request already issued by ex_stage. For memory instructions the
// stage waits here for the data_ok response. Load data is then aligned and
// sign/zero-extended. The result is handed to wb_stage over the valid/allowin
// handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ms_allowin          stage can accept an instruction this cycle
//   es_to_ms_valid/bus  upstream instruction
//                       bus layout: {pass, ms_ex, mem_req, load_op,
//                                    gr_we, dest, alu_result, pc}
//   ws_allowin          downstream ready
//   ms_to_ws_valid/bus  result to wb_stage
//                       bus layout: {pass, gr_we, dest, final_result, pc}
//   data_sram_data_ok   one-cycle response pulse
//   data_sram_rdata     read data, valid with data_ok
//   ws_flush_pipe       exception/ertn flush from wb_stage
//   ms_ex_out           valid instruction carrying an exception
//   ms_fwd_*            forwarding/stall information for the decode stage
module mem_stage #(
    parameter int unsigned PASS_W = 119,
    parameter int unsigned ES_W   = PASS_W + 75,
    parameter int unsigned WS_W   = PASS_W + 70
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ms_allowin,
    input  logic              es_to_ms_valid,
    input  logic [ES_W-1:0]   es_to_ms_bus,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [WS_W-1:0]   ms_to_ws_bus,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              ws_flush_pipe,
    output logic              ms_ex_out,
    output logic              ms_fwd_valid,
    output logic [4:0]        ms_fwd_dest,
    output logic              ms_fwd_ready,
    output logic [31:0]       ms_fwd_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_ms_valid;
    logic [ES_W-1:0]   r_es_bus;
    logic              r_buf_valid;
    logic [31:0]       r_buf_data;
    logic              r_drop_pending;

    // ------------------------------------------------------------------
    // Field decode of the captured ex->mem bus
    // ------------------------------------------------------------------
    logic [PASS_W-1:0] w_pass;
    logic              w_ms_ex;
    logic              w_mem_req;
    logic [2:0]        w_load_op;
    logic              w_gr_we;
    logic [4:0]        w_dest;
    logic [31:0]       w_alu_result;
    logic [31:0]       w_pc;

    assign w_pass       = r_es_bus[ES_W-1 -: PASS_W];
    assign w_ms_ex      = r_es_bus[74];
    assign w_mem_req    = r_es_bus[73];
    assign w_load_op    = r_es_bus[72:70];
    assign w_gr_we      = r_es_bus[69];
    assign w_dest       = r_es_bus[68:64];
    assign w_alu_result = r_es_bus[63:32];
    assign w_pc         = r_es_bus[31:0];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_resp_ok;
    logic w_ready_go;
    logic w_leave;

    // A response arriving while drop_pending belongs to a flushed request
    // and must not complete the instruction currently in the stage.
    assign w_resp_ok  = data_sram_data_ok && !r_drop_pending;

    assign w_ready_go = !w_mem_req || w_ms_ex || r_buf_valid || w_resp_ok;

    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go && !ws_flush_pipe;
    assign w_leave        = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ws_flush_pipe) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_bus <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            r_es_bus <= es_to_ms_bus;
        end
    end

    // ------------------------------------------------------------------
    // Read-data buffer: holds a response that arrived while wb_stage was
    // not accepting, so the one-cycle data_ok pulse is never lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (ws_flush_pipe || w_leave) begin
            r_buf_valid <= 1'b0;
        end else if (r_ms_valid && w_mem_req && w_resp_ok && !r_buf_valid) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Drop tracking for a request flushed before its response arrived.
    // The set term uses the filtered response so that a discarded pulse
    // coinciding with a second flush of a waiting load keeps the flag set.
    // ------------------------------------------------------------------
    logic w_drop_set;

    assign w_drop_set = ws_flush_pipe && r_ms_valid && w_mem_req &&
                        !r_buf_valid && !w_resp_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_pending <= 1'b0;
        end else if (w_drop_set) begin
            r_drop_pending <= 1'b1;
        end else if (data_sram_data_ok) begin
            r_drop_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    assign w_rdata = r_buf_valid ? r_buf_data : data_sram_rdata;

    always_comb begin
        w_byte = w_rdata[7:0];
        case (w_alu_result[1:0])
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
    end

    assign w_half = w_alu_result[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_load_data = w_rdata;
        case (w_load_op)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_rdata;
        endcase
    end

    // Stores carry gr_we=0 and therefore pass alu_result through.
    assign w_final_result = (w_mem_req && w_gr_we) ? w_load_data : w_alu_result;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ms_to_ws_bus = {w_pass, w_gr_we, w_dest, w_final_result, w_pc};

    assign ms_ex_out    = r_ms_valid && w_ms_ex;
    assign ms_fwd_valid = r_ms_valid && w_gr_we;
    assign ms_fwd_dest  = w_dest;
    assign ms_fwd_ready = w_ready_go;
    assign ms_fwd_data  = w_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by a randomized
// single-transaction sequence checked against a behavioural load model.
module tb_mem_stage;

    localparam int unsigned PASS_W = 119;
    localparam int unsigned ES_W   = PASS_W + 75;
    localparam int unsigned WS_W   = PASS_W + 70;

    logic            clk;
    logic            reset;
    logic            ms_allowin;
    logic            es_to_ms_valid;
    logic [ES_W-1:0] es_to_ms_bus;
    logic            ws_allowin;
    logic            ms_to_ws_valid;
    logic [WS_W-1:0] ms_to_ws_bus;
    logic            data_sram_data_ok;
    logic [31:0]     data_sram_rdata;
    logic            ws_flush_pipe;
    logic            ms_ex_out;
    logic            ms_fwd_valid;
    logic [4:0]      ms_fwd_dest;
    logic            ms_fwd_ready;
    logic [31:0]     ms_fwd_data;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mem_stage #(
        .PASS_W (PASS_W),
        .ES_W   (ES_W),
        .WS_W   (WS_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_flush_pipe     (ws_flush_pipe),
        .ms_ex_out         (ms_ex_out),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_ready      (ms_fwd_ready),
        .ms_fwd_data       (ms_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkbus(input string tag, input logic [WS_W-1:0] obs, input logic [WS_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic logic [ES_W-1:0] mk(input logic [PASS_W-1:0] p, input logic ex,
                                           input logic req, input logic [2:0] op,
                                           input logic gwe, input logic [4:0] dst,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {p, ex, req, op, gwe, dst, alu, pc};
    endfunction

    // Behavioural load model: shift the addressed unit down, mask it, and
    // add the sign fill when the top bit of the unit is set.
    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] alu,
                                            input logic [31:0] rd);
        int unsigned off;
        int unsigned v;
        off = {30'd0, alu[1:0]};
        if (op == 3'b000 || op == 3'b100) begin
            v = (rd >> (8 * off)) % 256;
            if (op == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (op == 3'b001 || op == 3'b101) begin
            v = (rd >> (16 * (off / 2))) % 65536;
            if (op == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic send(input logic [ES_W-1:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        at_neg();
        chk1("send_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    // Load with data_ok in its first cycle in the stage.
    task automatic load_now(input string tag, input logic [PASS_W-1:0] p, input logic [2:0] op,
                            input logic [31:0] alu, input logic [31:0] rd,
                            input logic [31:0] exp);
        send(mk(p, 1'b0, 1'b1, op, 1'b1, 5'd7, alu, 32'h1c00_0100));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        at_neg();
        chk1({tag, "_valid"}, ms_to_ws_valid, 1'b1);
        chk32(tag, ms_fwd_data, exp);
        chk32({tag, "_bus"}, ms_to_ws_bus[63:32], exp);
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        logic [PASS_W-1:0] p0;
        logic [PASS_W-1:0] p;
        logic [127:0]      r128;
        logic [31:0]       r32;
        logic [31:0]       alu;
        logic [31:0]       pc;
        logic [31:0]       rd;
        logic [31:0]       fin;
        logic [2:0]        op;
        logic [4:0]        dst;
        logic              ex;
        logic              req;
        logic              gwe;
        int unsigned       dly;
        int unsigned       stall;

        r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        p0   = r128[PASS_W-1:0];
        rd   = '0;

        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_flush_pipe     = 1'b0;

        // Reset state
        tick();
        tick();
        at_neg();
        chk1("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        chk1("rst_allowin", ms_allowin, 1'b1);
        chk1("rst_fwd_valid", ms_fwd_valid, 1'b0);
        chk1("rst_ex_out", ms_ex_out, 1'b0);
        tick();
        reset = 1'b0;

        // Non-memory add
        send(mk(p0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000));
        at_neg();
        chk1("add_valid", ms_to_ws_valid, 1'b1);
        chk1("add_fwd_ready", ms_fwd_ready, 1'b1);
        chk1("add_fwd_valid", ms_fwd_valid, 1'b1);
        chk32("add_fwd_dest", {27'd0, ms_fwd_dest}, 32'd5);
        chkbus("add_bus", ms_to_ws_bus, {p0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
        tick();
        at_neg();
        chk1("add_gone", ms_to_ws_valid, 1'b0);
        tick();

        // Same-cycle loads, all extension variants
        load_now("ld_b",  p0, 3'b000, 32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80);
        load_now("ld_bu", p0, 3'b100, 32'h0000_1003, 32'h80FF_0011, 32'h0000_0080);
        load_now("ld_hu", p0, 3'b101, 32'h0000_1002, 32'h80FF_0011, 32'h0000_80FF);
        load_now("ld_h",  p0, 3'b001, 32'h0000_1002, 32'h80FF_0011, 32'hFFFF_80FF);
        load_now("ld_h0", p0, 3'b001, 32'h0000_1000, 32'h80FF_0011, 32'h0000_0011);
        load_now("ld_w",  p0, 3'b010, 32'h0000_1000, 32'h80FF_0011, 32'h80FF_0011);
        load_now("ld_op7", p0, 3'b111, 32'h0000_1001, 32'h80FF_0011, 32'h80FF_0011);

        // Store passes alu_result
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0, 32'hA000_0010, 32'h1c00_0200));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        at_neg();
        chk32("store_result", ms_fwd_data, 32'hA000_0010);
        chk1("store_fwd_valid", ms_fwd_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;

        // Load with data_ok delayed 3 cycles
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd9, 32'h0000_2000, 32'h1c00_0300));
        for (int unsigned k = 0; k < 3; k++) begin
            data_sram_rdata = 32'hBAD0_0000 + k;
            at_neg();
            chk1("wait_valid", ms_to_ws_valid, 1'b0);
            chk1("wait_allowin", ms_allowin, 1'b0);
            chk1("wait_fwd_ready", ms_fwd_ready, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0123_4567;
        at_neg();
        chk1("delay_valid", ms_to_ws_valid, 1'b1);
        chk32("delay_data", ms_fwd_data, 32'h0123_4567);
        tick();
        data_sram_data_ok = 1'b0;

        // Back-pressure: response buffered for 2 cycles
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd3, 32'h0000_3000, 32'h1c00_0400));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_BABE;
        at_neg();
        chk1("bp_allowin", ms_allowin, 1'b0);
        chk32("bp_data0", ms_fwd_data, 32'hCAFE_BABE);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        at_neg();
        chk1("bp_valid1", ms_to_ws_valid, 1'b1);
        chk32("bp_data1", ms_fwd_data, 32'hCAFE_BABE);
        tick();
        ws_allowin = 1'b1;
        at_neg();
        chk1("bp_allowin2", ms_allowin, 1'b1);
        chk32("bp_data2", ms_to_ws_bus[63:32], 32'hCAFE_BABE);
        tick();
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd3, 32'h0000_3004, 32'h1c00_0404));
        at_neg();
        chk1("bp_buf_cleared", ms_fwd_ready, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_F00D;
        at_neg();
        chk32("bp_next_data", ms_fwd_data, 32'h0BAD_F00D);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush with a request outstanding, then a second load
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd4, 32'h0000_4000, 32'h1c00_0500));
        ws_flush_pipe = 1'b1;
        at_neg();
        chk1("fl_valid", ms_to_ws_valid, 1'b0);
        tick();
        ws_flush_pipe = 1'b0;
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd6, 32'h0000_4004, 32'h1c00_0504));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        at_neg();
        chk1("fl_drop_valid", ms_to_ws_valid, 1'b0);
        chk1("fl_drop_ready", ms_fwd_ready, 1'b0);
        tick();
        data_sram_rdata = 32'h2222_2222;
        at_neg();
        chk1("fl_second_valid", ms_to_ws_valid, 1'b1);
        chk32("fl_second_data", ms_fwd_data, 32'h2222_2222);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush coinciding with data_ok: nothing left to drop
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd6, 32'h0000_5000, 32'h1c00_0600));
        ws_flush_pipe     = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_3333;
        at_neg();
        chk1("flc_valid", ms_to_ws_valid, 1'b0);
        tick();
        ws_flush_pipe     = 1'b0;
        data_sram_data_ok = 1'b0;
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd6, 32'h0000_5004, 32'h1c00_0604));
        at_neg();
        chk1("flc_wait", ms_fwd_ready, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h4444_4444;
        at_neg();
        chk1("flc_next_valid", ms_to_ws_valid, 1'b1);
        chk32("flc_next_data", ms_fwd_data, 32'h4444_4444);
        tick();
        data_sram_data_ok = 1'b0;

        // Exception instruction passes through untouched
        send(mk(~p0, 1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0000_0001, 32'h1c00_0700));
        at_neg();
        chk1("ex_out", ms_ex_out, 1'b1);
        chkbus("ex_bus", ms_to_ws_bus, {~p0, 1'b0, 5'd0, 32'h0000_0001, 32'h1c00_0700});
        tick();

        // Asynchronous reset while a load waits
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd8, 32'h0000_6000, 32'h1c00_0800));
        at_neg();
        chk1("ar_pre_allowin", ms_allowin, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk1("ar_allowin", ms_allowin, 1'b1);
        chk1("ar_valid", ms_to_ws_valid, 1'b0);
        chk1("ar_fwd_valid", ms_fwd_valid, 1'b0);
        #1 reset = 1'b0;
        tick();

        // Reset clears drop_pending
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd8, 32'h0000_6004, 32'h1c00_0804));
        ws_flush_pipe = 1'b1;
        tick();
        ws_flush_pipe = 1'b0;
        at_neg();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        load_now("ar_drop_cleared", p0, 3'b010, 32'h0000_6008, 32'h5555_5555, 32'h5555_5555);

        // Reset clears the read-data buffer
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd8, 32'h0000_600C, 32'h1c00_080C));
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h6666_6666;
        tick();
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        at_neg();
        #1 reset = 1'b1;
        #1;
        chk1("ar_buf_valid", ms_to_ws_valid, 1'b0);
        #1 reset = 1'b0;
        tick();
        send(mk(p0, 1'b0, 1'b1, 3'b010, 1'b1, 5'd8, 32'h0000_6010, 32'h1c00_0810));
        at_neg();
        chk1("ar_buf_cleared", ms_fwd_ready, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        at_neg();
        chk32("ar_buf_next", ms_fwd_data, 32'h7777_7777);
        tick();
        data_sram_data_ok = 1'b0;

        // Randomized transactions against the load model
        for (int unsigned n = 0; n < 200; n++) begin
            r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            p    = r128[PASS_W-1:0];
            r32  = $urandom();
            ex   = (r32[2:0] == 3'd0);
            req  = !ex && r32[3];
            op   = r32[6:4];
            gwe  = req ? (r32[8:7] != 2'd0) : r32[9];
            dst  = r32[14:10];
            alu  = $urandom();
            pc   = $urandom();
            rd   = $urandom();
            send(mk(p, ex, req, op, gwe, dst, alu, pc));
            if (req) begin
                dly = $urandom_range(0, 3);
                for (int unsigned k = 0; k < dly; k++) begin
                    data_sram_rdata = $urandom();
                    at_neg();
                    chk1("rnd_wait_valid", ms_to_ws_valid, 1'b0);
                    chk1("rnd_wait_ready", ms_fwd_ready, 1'b0);
                    tick();
                end
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = rd;
            end
            fin   = (req && gwe) ? ref_ext(op, alu, rd) : alu;
            stall = $urandom_range(0, 2);
            ws_allowin = (stall == 0);
            for (int unsigned k = 0; k <= stall; k++) begin
                at_neg();
                chk1("rnd_valid", ms_to_ws_valid, 1'b1);
                chk1("rnd_allowin", ms_allowin, (k == stall));
                chk1("rnd_fwd_valid", ms_fwd_valid, gwe);
                chk1("rnd_ex_out", ms_ex_out, ex);
                chk32("rnd_fwd_data", ms_fwd_data, fin);
                chkbus("rnd_bus", ms_to_ws_bus, {p, gwe, dst, fin, pc});
                tick();
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom();
                ws_allowin        = (k + 1 == stall);
            end
            ws_allowin = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage LoongArch pipeline, between ex_stage (upstream) and wb_stage (downstream).
- Receives instructions whose data-SRAM request ex_stage has already issued, and waits for the data_ok response.
- For loads it aligns and sign/zero-extends the read data; then it hands the result to wb_stage over the valid/allowin handshake.
- Publishes a forwarding/stall interface to the decode stage, and holds a read-data buffer so a response is never lost while wb_stage back-pressures.

Parameters:
- PASS_W, 119, width of the opaque exception/CSR field carried untouched from ex to wb (it ends at wb_vaddr).
- ES_W, PASS_W+75, width of es_to_ms_bus.
- WS_W, PASS_W+70, width of ms_to_ws_bus. Must equal the wb_stage bus width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ms_allowin  out  1  stage can accept an instruction this cycle
- es_to_ms_valid  in  1  upstream instruction valid
- es_to_ms_bus  in  ES_W  fields, MSB to LSB:
  - pass[PASS_W-1:0]
  - ms_ex, 1
  - mem_req, 1: a data-SRAM request was issued
  - load_op, 3
  - gr_we, 1
  - dest, 5
  - alu_result, 32
  - pc, 32
- ws_allowin  in  1  downstream ready
- ms_to_ws_valid  out  1  result valid to wb_stage
- ms_to_ws_bus  out  WS_W  {pass, gr_we, dest, final_result[31:0], pc[31:0]}
- data_sram_data_ok  in  1  one-cycle read/write response pulse
- data_sram_rdata  in  32  read data, valid with data_ok
- ws_flush_pipe  in  1  exception/ertn flush from wb_stage
- ms_ex_out  out  1  ms_valid && ms_ex; ex_stage suppresses new stores when high
- ms_fwd_valid  out  1  ms_valid && gr_we
- ms_fwd_dest  out  5  dest
- ms_fwd_ready  out  1  ms_ready_go, i.e. ms_fwd_data is final
- ms_fwd_data  out  32  final_result

Behaviour:
- Reset (asynchronous):
  - ms_valid=0, bus register=0, data_buf_valid=0, drop_pending=0.
  - Hence ms_to_ws_valid=0, ms_ex_out=0, ms_fwd_valid=0.
- Pipeline handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe.
  - If ms_allowin: ms_valid <= es_to_ms_valid. The bus is captured only when es_to_ms_valid && ms_allowin.
  - ws_flush_pipe has priority over everything: ms_valid <= 0 next cycle.
- Response wait:
  - ms_ready_go = !mem_req || ms_ex || data_buf_valid || data_sram_data_ok.
  - A non-memory instruction advances in one cycle. A memory instruction advances in the cycle data_ok arrives, or later out of the buffer.
- Data buffer:
  - Set data_buf_valid and capture rdata when ms_valid && mem_req && data_ok && !drop_pending && !(ws_allowin && ms_to_ws_valid).
  - Clear it when the instruction leaves (ms_to_ws_valid && ws_allowin) or on flush.
  - Read data source = data_buf_valid ? buffered data : data_sram_rdata.
- Flush with a request outstanding:
  - If ws_flush_pipe while ms_valid && mem_req && !data_buf_valid && !data_ok, set drop_pending.
  - The next data_ok is consumed and discarded, and drop_pending clears.
  - While drop_pending=1, a newly arrived memory instruction must not treat that data_ok as its own; its own response comes after.
  - If flush and data_ok coincide, the response is dropped and drop_pending is not set.
- Load extension (offset = alu_result[1:0]):
  - 000 ld.b: sign-extend the byte at offset.
  - 100 ld.bu: zero-extend the byte at offset.
  - 001 ld.h: sign-extend the halfword at offset[1] (offset[0] is assumed 0; ALE is raised upstream).
  - 101 ld.hu: zero-extend the halfword at offset[1].
  - 010 ld.w: the full word.
  - Other codes: treated as ld.w.
- final_result = (mem_req && load_op valid-load && gr_we) ? extended data : alu_result. Stores have gr_we=0 and pass alu_result.
- Latency:
  - Non-memory: 1 cycle in stage.
  - Load: cycles until data_ok, minimum 1 (data_ok in the same cycle the instruction is in MS).
- Exceptions: ms_ex instructions never wait and pass pass-field and pc unchanged. Upstream guarantees mem_req=0 for them.

Test Plan:
- Non-memory add: pc=0x1c000000, alu_result=0x12345678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_fwd_ready=1.
- ld.b, alu_result[1:0]=3, data_ok with rdata=0x80FF_0011 in the same cycle -> final_result=0xFFFFFF80. ld.bu with the same stimulus -> 0x00000080. ld.hu, offset 2 -> 0x000080FF.
- Load with data_ok delayed 3 cycles -> ms_ready_go=0, ms_allowin=0, ms_fwd_ready=0 for 3 cycles, then advance with the correct data.
- data_ok=1, rdata=0xCAFEBABE while ws_allowin=0 for 2 cycles; drive rdata to garbage afterwards -> wb receives 0xCAFEBABE once ws_allowin=1, and data_buf_valid clears.
- Flush while a load is outstanding; a second load enters; then two data_ok pulses with 0x11111111 and 0x22222222 -> the first is discarded, the second load's final_result=0x22222222.
- Assert reset mid-wait (asynchronous, between clock edges) -> ms_valid, ms_to_ws_valid, data_buf_valid and drop_pending go to 0 immediately.
